// File: rtl/foo_share_sched.sv
// Round-robin time-share of one foo datapath; responses return FOO_LAT+2 cycles after handshake, no rsp backpressure.
// Optional per-requester grant counters (grant_cnt/stats_clr) under FOO_SHARE_SCHED_STATS_EN.
module foo_share_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int FOO_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        idle,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [DATA_W-1:0]           foo_a,
  input  logic [DATA_W-1:0]           foo_x
`ifdef FOO_SHARE_SCHED_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = FOO_LAT + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  tag_t [DEPTH-1:0]      tag_q, tag_d;
  logic [DATA_W-1:0]     foo_a_q, foo_a_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic                  pipe_busy;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    if (state_q == ST_RUN && en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_vld && req_valid[j]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
      req_ready[grant_idx] = grant_vld;
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) pipe_busy = pipe_busy | tag_q[k].vld;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)             state_d = ST_RUN;
        else if (!pipe_busy) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    foo_a_d     = foo_a_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      foo_a_d  = req_data[grant_idx*DATA_W +: DATA_W];
    end
    tag_d[0].vld = grant_vld;
    tag_d[0].idx = grant_idx;
    for (int k = 1; k < DEPTH; k++) tag_d[k] = tag_q[k-1];
    // Last stage lines up with foo_x for the operand issued FOO_LAT+1 cycles ago.
    if (tag_q[DEPTH-1].vld) begin
      rsp_valid_d[tag_q[DEPTH-1].idx] = 1'b1;
      rsp_data_d                      = foo_x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      tag_q       <= '0;
      foo_a_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_q       <= tag_d;
      foo_a_q     <= foo_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign foo_a     = foo_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = (state_q == ST_IDLE) && !pipe_busy && !(|rsp_valid_q);

`ifdef FOO_SHARE_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Clear wins over a same-cycle grant; counters saturate.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr)
        cnt_d[i] = '0;
      else if (grant_vld && grant_idx == IDX_W'(i) && cnt_q[i] != 16'hFFFF)
        cnt_d[i] = cnt_q[i] + 16'd1;
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_n) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_foo_share_sched.sv
// Bench for foo_share_sched: directed scenarios plus random traffic against a queue-based issue/response model.
module tb_foo_share_sched;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int FOO_LAT = 1;
  localparam int RSP_LAT = FOO_LAT + 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic                      clk = 1'b0;
  logic                      rst_n, en, idle;
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         rsp_data, foo_a, foo_x;
`ifdef FOO_SHARE_SCHED_STATS_EN
  logic                      stats_clr;
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  foo_share_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FOO_LAT(FOO_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .idle(idle),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .foo_a(foo_a), .foo_x(foo_x)
`ifdef FOO_SHARE_SCHED_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] foo_fn(input logic [DATA_W-1:0] a);
    return ({a[DATA_W-14:0], a[DATA_W-1:DATA_W-13]} ^ 64'h0F1E_2D3C_4B5A_6978) + a;
  endfunction

  // Stand-in for the shared foo: FOO_LAT register stages.
  logic [DATA_W-1:0] foo_pipe [FOO_LAT];
  always @(posedge clk) begin
    foo_pipe[0] <= foo_fn(foo_a);
    for (int k = 1; k < FOO_LAT; k++) foo_pipe[k] <= foo_pipe[k-1];
  end
  assign foo_x = foo_pipe[FOO_LAT-1];

  typedef struct {
    int                issue;
    int                idx;
    logic [DATA_W-1:0] data;
  } op_t;

  op_t               pend[$];
  int                mode, rr, cyc;
  logic [DATA_W-1:0] exp_foo_a, exp_rsp_data;
  int                exp_cnt [NUM_REQ];
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ*DATA_W-1:0] rnd_d();
    logic [NUM_REQ*DATA_W-1:0] r;
    for (int i = 0; i < NUM_REQ*DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    pend.delete();
    mode         = M_IDLE;
    rr           = 0;
    exp_foo_a    = '0;
    exp_rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_cnt[i] = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = '0;
`ifdef FOO_SHARE_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = cyc + n;
    model_reset();
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input logic e, input logic [NUM_REQ-1:0] v,
                      input logic [NUM_REQ*DATA_W-1:0] d, input logic clr);
    int                 g;
    bit                 busy;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    logic               exp_idle;
    en        = e;
    req_valid = v;
    req_data  = d;
`ifdef FOO_SHARE_SCHED_STATS_EN
    stats_clr = clr;
`endif
    #1;
    g = -1;
    if (mode == M_RUN && e)
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && v[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
    exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    exp_rv    = '0;
    if (pend.size() > 0 && pend[0].issue + RSP_LAT == cyc) begin
      exp_rv       = NUM_REQ'(1 << pend[0].idx);
      exp_rsp_data = foo_fn(pend[0].data);
    end
    exp_idle = (mode == M_IDLE) && (pend.size() == 0);

    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_data",  rsp_data,  exp_rsp_data);
    check("foo_a",     foo_a,     exp_foo_a);
    check("idle",      idle,      exp_idle);
`ifdef FOO_SHARE_SCHED_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) check("grant_cnt", grant_cnt[i*16 +: 16], exp_cnt[i]);
`endif

    busy = 1'b0;
    foreach (pend[i]) if (pend[i].issue + RSP_LAT > cyc) busy = 1'b1;
    if (exp_rv != '0) void'(pend.pop_front());
    if (g >= 0) begin
      pend.push_back('{issue: cyc, idx: g, data: d[g*DATA_W +: DATA_W]});
      exp_foo_a = d[g*DATA_W +: DATA_W];
      rr        = (g + 1) % NUM_REQ;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (clr) exp_cnt[i] = 0;
      else if (g == i && exp_cnt[i] < 65535) exp_cnt[i]++;
    case (mode)
      M_IDLE:  if (e) mode = M_RUN;
      M_RUN:   if (!e) mode = M_DRAIN;
      default: if (e) mode = M_RUN; else if (!busy) mode = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [NUM_REQ*DATA_W-1:0] d;
    cyc = 0;
    req_data = '0;
    do_reset(2);

    // Reset state, then first single op with 0x1234
    step(0, 2'b00, '0, 0);
    step(1, 2'b00, '0, 0);
    d = '0;
    d[DATA_W-1:0] = 64'h1234;
    step(1, 2'b01, d, 0);
    repeat (4) step(1, 2'b00, rnd_d(), 0);

    // Both requesters continuously valid: strict alternation
    repeat (6) step(1, 2'b11, rnd_d(), 0);
    repeat (4) step(1, 2'b00, rnd_d(), 0);

    // Only requester 1, data 1..4
    for (int i = 1; i <= 4; i++) begin
      d = '0;
      d[DATA_W +: DATA_W] = DATA_W'(i);
      step(1, 2'b10, d, 0);
    end
    repeat (4) step(1, 2'b00, rnd_d(), 0);

    // Three ops then drain with en low and requests still asserted
    repeat (3) step(1, 2'b11, rnd_d(), 0);
    repeat (7) step(0, 2'b11, rnd_d(), 0);

    // en toggling mid-drain
    repeat (3) step(1, 2'b11, rnd_d(), 0);
    step(0, 2'b11, rnd_d(), 0);
    step(1, 2'b01, rnd_d(), 0);
    step(1, 2'b10, rnd_d(), 0);
    repeat (6) step(0, 2'b00, rnd_d(), 0);

    // Reset with two ops in flight, then rotation must restart at 0
    step(1, 2'b00, rnd_d(), 0);
    repeat (2) step(1, 2'b11, rnd_d(), 0);
    do_reset(1);
    repeat (3) step(0, 2'b00, rnd_d(), 0);
    step(1, 2'b11, rnd_d(), 0);
    repeat (3) step(1, 2'b11, rnd_d(), 0);
    repeat (5) step(0, 2'b00, rnd_d(), 0);

    // 5 grants to requester 0, 3 to requester 1, then clear
    step(1, 2'b00, rnd_d(), 0);
    repeat (5) step(1, 2'b01, rnd_d(), 0);
    repeat (3) step(1, 2'b10, rnd_d(), 0);
    step(1, 2'b00, rnd_d(), 0);
    step(1, 2'b01, rnd_d(), 1);
    step(1, 2'b00, rnd_d(), 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 200) == 0) do_reset($urandom_range(1, 2));
      step(($urandom_range(0, 5) != 0), NUM_REQ'($urandom), rnd_d(), ($urandom_range(0, 40) == 0));
    end
    repeat (8) step(0, 2'b00, rnd_d(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
